calendar_ctrl: RTL and testbench
================================

// Module: calendar_ctrl
// PURPOSE
//  Sequencer for the calendar counters (date, month, year). It turns the midnight carry into
//  cascaded step pulses and runs the user set-mode FSM that drives each counter's load/data.
//  It also arbitrates the shared display databus by asserting exactly one counter enable.
//  Sits between the time-of-day counters / push-button debouncers and the calendar counters.
// PARAMETERS
//  DAYS_PER_MONTH  30    last date value; the next date after it is 1
//  MONTHS          12    last month value; the next month after it is 1
//  YEAR_MAX        99    last year value; the next year after it is 0
//  SCAN_DIV        1000  clk cycles per display-field dwell in RUN (>=2)
//  TIMEOUT         5000  idle clk cycles in a SET state before abort (>=2)
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst_n      in   1  synchronous, active-low reset
//  day_tick   in   1  1-cycle pulse, midnight carry from the hours counter
//  btn_mode   in   1  1-cycle debounced pulse: enter set / next field
//  btn_inc    in   1  1-cycle debounced pulse: increment field being edited
//  cur_date   in   5  current date counter value (1..30)
//  cur_month  in   4  current month counter value (1..12)
//  cur_year   in   7  current year counter value (0..99)
//  date_step  out  1  1-cycle advance pulse to the date counter
//  month_step out  1  1-cycle advance pulse to the month counter
//  year_step  out  1  1-cycle advance pulse to the year counter
//  date_ld    out  1  1-cycle load strobe, date counter
//  month_ld   out  1  1-cycle load strobe, month counter
//  year_ld    out  1  1-cycle load strobe, year counter
//  ld_data    out  7  load value, valid while any *_ld=1 (zero-extended for date/month)
//  date_en    out  1  databus enable, date counter (one-hot with month_en/year_en)
//  month_en   out  1  databus enable, month counter
//  year_en    out  1  databus enable, year counter
//  editing    out  1  high in any SET state (drives field blink)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=RUN; all *_step/*_ld=0; ld_data=0; date_en=1,
//   month_en=year_en=0; editing=0; scan and timeout counters=0; edit register=0.
//  FSM states: RUN -> SET_DATE -> SET_MONTH -> SET_YEAR -> RUN.
//  RUN: day_tick at cycle N -> date_step=1 at N+1 (registered, latency 1).
//   - If cur_date==DAYS_PER_MONTH at N, month_step=1 at N+1.
//   - If cur_month==MONTHS too, year_step=1 at N+1 (year counter wraps itself).
//  RUN + btn_mode -> SET_DATE; edit<=cur_date; editing=1 next cycle.
//  SET_x + btn_inc -> edit+1 with wrap: date 30->1, month 12->1, year 99->0.
//  SET_x + btn_mode: the matching *_ld pulses 1 cycle with ld_data=edit.
//   - Advance: SET_DATE->SET_MONTH (edit<=cur_month), SET_MONTH->SET_YEAR (edit<=cur_year).
//   - SET_YEAR + btn_mode: year_ld pulses, state -> RUN.
//  btn_mode and btn_inc in the same cycle: mode wins; inc is ignored.
//  Timeout: counter clears on any button pulse and on entering a SET state; it counts each
//   idle SET cycle. At TIMEOUT-1 -> RUN. No load for the current field; earlier fields stay.
//  Never in a SET state: *_step. Never in RUN: *_ld. Never in the same cycle: *_ld and *_step.
//  Bus arbitration: exactly one *_en high every cycle.
//   - RUN: rotate date->month->year->date every SCAN_DIV cycles.
//   - SET_x: the edited field's enable is held; the scan counter resets.
//   - Rotation resumes at date on return to RUN.
//  Reset mid-SET aborts the edit: no load strobe, all outputs return to reset values.
// CONFIGURATION
//  TICK_DEFER_EN defined:
//   - A day_tick that arrives in a SET state sets a pending flag.
//   - The flag is applied as a normal RUN tick in the first cycle after return to RUN, then cleared.
//   - It uses the counter values in that cycle; multiple ticks collapse to one.
//  TICK_DEFER_EN undefined: a day_tick in any SET state is dropped.
// TESTING
//  T1 reset: rst_n=0 two cycles -> state RUN, date_en=1, all strobes 0, ld_data=0.
//  T2 carry: cur_date=30, cur_month=12, day_tick -> next cycle date/month/year_step all 1.
//     Same with cur_date=17 -> only date_step=1.
//  T3 set: btn_mode; 3x btn_inc (cur_date=29) -> date_ld=1, ld_data=2.
//     Month edit from 12 with 1 inc -> month_ld, ld_data=1.
//     Year 99 + 1 inc -> year_ld, ld_data=0; then RUN.
//  T4 collisions: btn_mode+btn_inc same cycle in SET_DATE -> SET_MONTH, edit unchanged.
//     day_tick in SET_MONTH -> no *_step (macro off).
//     Macro on: one date_step in the cycle after RUN re-entry.
//  T5 timeout: enter SET_DATE, no buttons for TIMEOUT cycles -> RUN, no date_ld, editing=0.
//  T6 bus: in RUN, one-hot *_en checked every cycle; field changes exactly every SCAN_DIV cycles.
//     In SET_MONTH month_en is held.

Source files
------------

// File: rtl/calendar_ctrl.sv
// rtl/calendar_ctrl.sv - calendar sequencer: day carry cascade, set-mode FSM, display bus arbitration
//
// Purpose:
//   Turns the midnight carry into cascaded date/month/year step pulses, runs the
//   user set-mode FSM (RUN -> SET_DATE -> SET_MONTH -> SET_YEAR -> RUN) that drives
//   each counter's load strobe and load data, and arbitrates the shared display
//   databus so that exactly one counter enable is high every cycle.
//
// Configuration:
//   TICK_DEFER_EN - when defined, a day_tick arriving while editing is remembered
//                   and applied in the first RUN cycle after the edit ends; when
//                   undefined, such a tick is dropped.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   day_tick                           midnight carry pulse from the hours counter
//   btn_mode, btn_inc                  debounced button pulses
//   cur_date[4:0], cur_month[3:0],
//   cur_year[6:0]                      current calendar counter values
//   date_step, month_step, year_step   registered advance pulses
//   date_ld, month_ld, year_ld         registered load strobes
//   ld_data[6:0]                       load value, valid with any *_ld
//   date_en, month_en, year_en         one-hot databus enables
//   editing                            high in any SET state

module calendar_ctrl #(
  parameter int DAYS_PER_MONTH = 30,
  parameter int MONTHS         = 12,
  parameter int YEAR_MAX       = 99,
  parameter int SCAN_DIV       = 1000,
  parameter int TIMEOUT        = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       day_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_date,
  input  logic [3:0] cur_month,
  input  logic [6:0] cur_year,
  output logic       date_step,
  output logic       month_step,
  output logic       year_step,
  output logic       date_ld,
  output logic       month_ld,
  output logic       year_ld,
  output logic [6:0] ld_data,
  output logic       date_en,
  output logic       month_en,
  output logic       year_en,
  output logic       editing
);

  localparam int TW = (TIMEOUT  > 2) ? $clog2(TIMEOUT)  : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_SET_DATE  = 2'd1,
    S_SET_MONTH = 2'd2,
    S_SET_YEAR  = 2'd3
  } state_t;

  localparam logic [1:0] F_DATE  = 2'd0;
  localparam logic [1:0] F_MONTH = 2'd1;
  localparam logic [1:0] F_YEAR  = 2'd2;

  state_t        state_q, state_d;
  logic [6:0]    edit_q, edit_d;
  logic [TW-1:0] to_q, to_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    field_q, field_d;
  logic          date_step_q, date_step_d;
  logic          month_step_q, month_step_d;
  logic          year_step_q, year_step_d;
  logic          date_ld_q, date_ld_d;
  logic          month_ld_q, month_ld_d;
  logic          year_ld_q, year_ld_d;
  logic [6:0]    ld_data_q, ld_data_d;
`ifdef TICK_DEFER_EN
  logic          pend_q, pend_d;
`endif

  logic          tick_run;
  logic [6:0]    edit_inc;

  // Increment of the field under edit, wrapping at that field's limit.
  always_comb begin
    edit_inc = edit_q + 7'd1;
    case (state_q)
      S_SET_DATE:  if (edit_q >= 7'(DAYS_PER_MONTH)) edit_inc = 7'd1;
      S_SET_MONTH: if (edit_q >= 7'(MONTHS))         edit_inc = 7'd1;
      S_SET_YEAR:  if (edit_q >= 7'(YEAR_MAX))       edit_inc = 7'd0;
      default:     edit_inc = edit_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    edit_d       = edit_q;
    to_d         = to_q;
    scan_d       = scan_q;
    field_d      = field_q;
    date_step_d  = 1'b0;
    month_step_d = 1'b0;
    year_step_d  = 1'b0;
    date_ld_d    = 1'b0;
    month_ld_d   = 1'b0;
    year_ld_d    = 1'b0;
    ld_data_d    = 7'd0;
    tick_run     = 1'b0;
`ifdef TICK_DEFER_EN
    pend_d       = pend_q;
`endif

    case (state_q)
      S_RUN: begin
        to_d = '0;
        // Scan rotation of the display field.
        if (scan_q == SW'(SCAN_DIV - 1)) begin
          scan_d  = '0;
          field_d = (field_q == F_YEAR) ? F_DATE : field_q + 2'd1;
        end else begin
          scan_d = scan_q + SW'(1);
        end
        if (btn_mode) begin
          // A tick in the entry cycle would produce a step while already
          // editing, so it is treated like a tick arriving in SET.
          state_d = S_SET_DATE;
          edit_d  = {2'b00, cur_date};
`ifdef TICK_DEFER_EN
          pend_d  = pend_q | day_tick;
`endif
        end else begin
`ifdef TICK_DEFER_EN
          tick_run = day_tick | pend_q;
          pend_d   = 1'b0;
`else
          tick_run = day_tick;
`endif
        end
      end

      default: begin
        // Editing: the edited field owns the bus; rotation restarts at date.
        scan_d  = '0;
        field_d = F_DATE;
`ifdef TICK_DEFER_EN
        if (day_tick) pend_d = 1'b1;
`endif
        if (btn_mode) begin
          to_d      = '0;
          ld_data_d = edit_q;
          case (state_q)
            S_SET_DATE: begin
              date_ld_d = 1'b1;
              state_d   = S_SET_MONTH;
              edit_d    = {3'b000, cur_month};
            end
            S_SET_MONTH: begin
              month_ld_d = 1'b1;
              state_d    = S_SET_YEAR;
              edit_d     = cur_year;
            end
            default: begin
              year_ld_d = 1'b1;
              state_d   = S_RUN;
            end
          endcase
        end else if (btn_inc) begin
          to_d   = '0;
          edit_d = edit_inc;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          // Abandon the edit without loading the current field.
          to_d    = '0;
          state_d = S_RUN;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
    endcase

    if (tick_run) begin
      date_step_d  = 1'b1;
      month_step_d = (cur_date == 5'(DAYS_PER_MONTH));
      year_step_d  = (cur_date == 5'(DAYS_PER_MONTH)) && (cur_month == 4'(MONTHS));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      edit_q       <= 7'd0;
      to_q         <= '0;
      scan_q       <= '0;
      field_q      <= F_DATE;
      date_step_q  <= 1'b0;
      month_step_q <= 1'b0;
      year_step_q  <= 1'b0;
      date_ld_q    <= 1'b0;
      month_ld_q   <= 1'b0;
      year_ld_q    <= 1'b0;
      ld_data_q    <= 7'd0;
`ifdef TICK_DEFER_EN
      pend_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      edit_q       <= edit_d;
      to_q         <= to_d;
      scan_q       <= scan_d;
      field_q      <= field_d;
      date_step_q  <= date_step_d;
      month_step_q <= month_step_d;
      year_step_q  <= year_step_d;
      date_ld_q    <= date_ld_d;
      month_ld_q   <= month_ld_d;
      year_ld_q    <= year_ld_d;
      ld_data_q    <= ld_data_d;
`ifdef TICK_DEFER_EN
      pend_q       <= pend_d;
`endif
    end
  end

  // Bus enables come straight from state/field flops so they are one-hot
  // in every cycle, including the reset cycle.
  always_comb begin
    date_en  = 1'b0;
    month_en = 1'b0;
    year_en  = 1'b0;
    case (state_q)
      S_SET_DATE:  date_en  = 1'b1;
      S_SET_MONTH: month_en = 1'b1;
      S_SET_YEAR:  year_en  = 1'b1;
      default: begin
        case (field_q)
          F_MONTH: month_en = 1'b1;
          F_YEAR:  year_en  = 1'b1;
          default: date_en  = 1'b1;
        endcase
      end
    endcase
  end

  assign editing    = (state_q != S_RUN);
  assign date_step  = date_step_q;
  assign month_step = month_step_q;
  assign year_step  = year_step_q;
  assign date_ld    = date_ld_q;
  assign month_ld   = month_ld_q;
  assign year_ld    = year_ld_q;
  assign ld_data    = ld_data_q;

endmodule

// File: tb/tb_calendar_ctrl.sv
// tb/tb_calendar_ctrl.sv - self-checking bench for calendar_ctrl

module tb_calendar_ctrl;

  localparam int SCAN_DIV = 8;
  localparam int TIMEOUT  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       day_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_date = 5'd1;
  logic [3:0] cur_month = 4'd1;
  logic [6:0] cur_year = 7'd0;
  logic       date_step, month_step, year_step;
  logic       date_ld, month_ld, year_ld;
  logic [6:0] ld_data;
  logic       date_en, month_en, year_en, editing;

  int n_chk = 0;
  int n_bad = 0;

  // Expected strobe word: {date_step, month_step, year_step, date_ld, month_ld, year_ld, ld_data}
  logic [12:0] exp_q[$];

  calendar_ctrl #(
    .DAYS_PER_MONTH(30), .MONTHS(12), .YEAR_MAX(99),
    .SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_date(cur_date), .cur_month(cur_month), .cur_year(cur_year),
    .date_step(date_step), .month_step(month_step), .year_step(year_step),
    .date_ld(date_ld), .month_ld(month_ld), .year_ld(year_ld), .ld_data(ld_data),
    .date_en(date_en), .month_en(month_en), .year_en(year_en), .editing(editing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] steps(input bit d, input bit m, input bit y);
    return {d, m, y, 3'b000, 7'd0};
  endfunction

  function automatic logic [12:0] load(input int fld, input int data);
    logic [2:0] l;
    l = (fld == 0) ? 3'b100 : (fld == 1) ? 3'b010 : 3'b001;
    return {3'b000, l, 7'(data)};
  endfunction

  // Output monitor: one-hot bus every cycle, strobes matched against the scoreboard.
  logic [12:0] got_w;
  logic [12:0] exp_w;
  always begin
    @(posedge clk);
    #1;
    check("onehot_en", $countones({date_en, month_en, year_en}), 1);
    got_w = {date_step, month_step, year_step, date_ld, month_ld, year_ld, ld_data};
    if (got_w[12:7] != 6'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", int'(got_w), 0);
      end else begin
        exp_w = exp_q.pop_front();
        check("strobe_word", int'(got_w), int'(exp_w));
      end
    end else if (got_w[6:0] != 7'd0) begin
      check("ld_data_idle", int'(got_w[6:0]), 0);
    end
  end

  initial begin
    // T1 reset
    rst_n = 1'b0;
    step();
    step();
    check("rst_date_en", date_en, 1);
    check("rst_month_en", month_en, 0);
    check("rst_year_en", year_en, 0);
    check("rst_editing", editing, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_strobes", {date_step, month_step, year_step, date_ld, month_ld, year_ld}, 0);
    rst_n = 1'b1;

    // T6 bus rotation from reset release: field = (k / SCAN_DIV) % 3 after k edges
    for (int k = 1; k <= 3 * SCAN_DIV + 2; k++) begin
      step();
      check("scan_field", {date_en, month_en, year_en},
            ((k / SCAN_DIV) % 3 == 0) ? 3'b100 : ((k / SCAN_DIV) % 3 == 1) ? 3'b010 : 3'b001);
    end

    // T2 carry cascade
    cur_date = 5'd30; cur_month = 4'd12; day_tick = 1'b1;
    exp_q.push_back(steps(1, 1, 1));
    step();
    day_tick = 1'b0;
    cur_date = 5'd17; day_tick = 1'b1;
    exp_q.push_back(steps(1, 0, 0));
    step();
    day_tick = 1'b0;
    cur_date = 5'd30; cur_month = 4'd5; day_tick = 1'b1;
    exp_q.push_back(steps(1, 1, 0));
    step();
    day_tick = 1'b0;
    step();

    // T3 full set sequence with wraps
    cur_date = 5'd29; cur_month = 4'd12; cur_year = 7'd99;
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    check("set_editing", editing, 1);
    check("set_date_en", date_en, 1);
    for (int i = 0; i < 3; i++) begin
      btn_inc = 1'b1; step(); btn_inc = 1'b0;
    end
    btn_mode = 1'b1; exp_q.push_back(load(0, 2)); step(); btn_mode = 1'b0;
    check("set_month_en", month_en, 1);
    step();
    check("set_month_en_held", month_en, 1);
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    btn_mode = 1'b1; exp_q.push_back(load(1, 1)); step(); btn_mode = 1'b0;
    check("set_year_en", year_en, 1);
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    btn_mode = 1'b1; exp_q.push_back(load(2, 0)); step(); btn_mode = 1'b0;
    check("back_run_editing", editing, 0);
    check("back_run_date_en", date_en, 1);
    step();

    // T4 collisions
    cur_date = 5'd5; cur_month = 4'd3; cur_year = 7'd40;
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    btn_mode = 1'b1; btn_inc = 1'b1; exp_q.push_back(load(0, 6)); step();
    btn_mode = 1'b0; btn_inc = 1'b0;
    check("coll_month_en", month_en, 1);
    day_tick = 1'b1; step(); day_tick = 1'b0;
    step();
    btn_mode = 1'b1; exp_q.push_back(load(1, 3)); step(); btn_mode = 1'b0;
    btn_mode = 1'b1; exp_q.push_back(load(2, 40));
`ifdef TICK_DEFER_EN
    exp_q.push_back(steps(1, 0, 0));
`endif
    step(); btn_mode = 1'b0;
    step(); step(); step();

    // T5 timeout boundary
    cur_date = 5'd10;
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("to_still_editing", editing, 1);
    step();
    check("to_editing_off", editing, 0);
    check("to_date_en", date_en, 1);
    step(); step();

    // Reset mid-edit aborts without a load
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    rst_n = 1'b0; step();
    check("midrst_editing", editing, 0);
    check("midrst_date_en", date_en, 1);
    rst_n = 1'b1;
    step(); step();

    check("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
